alu_result_checker: RTL and testbench

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

---
 rtl/alu_result_checker.sv | 188 ++++++++++++++++++
 tb/tb_alu_result_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// Compares the primitive and always-block ALU results after a settle window and keeps pass/fail statistics.
// Optional first-failure capture of R_P/R_A is enabled by defining ALU_CHK_FAIL_LOG_EN.
module alu_result_checker #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        clear,
   input  logic [15:0] R_P,
   input  logic [15:0] R_A,
   input  logic        Co_P,
   input  logic        V_P,
   input  logic        Z_P,
   input  logic        Co_A,
   input  logic        V_A,
   input  logic        Z_A,
   output logic        busy,
   output logic        done,
   output logic        match,
   output logic [3:0]  diff_flags,
   output logic [7:0]  test_count,
   output logic [7:0]  mismatch_count,
   output logic [15:0] fail_R_P,
   output logic [15:0] fail_R_A
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      COMPARE = 2'd2,
      REPORT  = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic        busy_q;
   logic        done_q;
   logic        match_q;
   logic [3:0]  diff_q;
   logic [7:0]  test_cnt_q;
   logic [7:0]  test_cnt_d;
   logic [7:0]  mis_cnt_q;
   logic [7:0]  mis_cnt_d;
   logic        compare_s;
   logic [3:0]  diff_s;
   logic        fail_s;

   assign compare_s = (state_q == COMPARE);
   assign diff_s    = {(R_P != R_A), (Co_P != Co_A), (V_P != V_A), (Z_P != Z_A)};
   assign fail_s    = compare_s && (diff_s != 4'd0);

   // State and settle-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; start is only looked at in IDLE so it cannot restart a run.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETTLE;
               cnt_d   = SETTLE_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         SETTLE: begin
            if (cnt_q == 4'd0) begin
               state_d = COMPARE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         COMPARE: state_d = REPORT;
         REPORT:  state_d = IDLE;
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Registered status outputs; done lines up with the freshly sampled result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
         diff_q  <= 4'd0;
      end else begin
         busy_q <= (state_d != IDLE);
         done_q <= compare_s;
         if (compare_s) begin
            diff_q  <= diff_s;
            match_q <= (diff_s == 4'd0);
         end else begin
            diff_q  <= diff_q;
            match_q <= match_q;
         end
      end
   end

   // Counter next-state: clear has priority over a same-edge compare update.
   always_comb begin
      test_cnt_d = test_cnt_q;
      mis_cnt_d  = mis_cnt_q;
      if (clear) begin
         test_cnt_d = 8'd0;
         mis_cnt_d  = 8'd0;
      end else if (compare_s) begin
         test_cnt_d = test_cnt_q + 8'd1;
         if (fail_s && (mis_cnt_q != 8'd255)) begin
            mis_cnt_d = mis_cnt_q + 8'd1;
         end else begin
            mis_cnt_d = mis_cnt_q;
         end
      end else begin
         test_cnt_d = test_cnt_q;
         mis_cnt_d  = mis_cnt_q;
      end
   end

   // Statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         test_cnt_q <= 8'd0;
         mis_cnt_q  <= 8'd0;
      end else begin
         test_cnt_q <= test_cnt_d;
         mis_cnt_q  <= mis_cnt_d;
      end
   end

`ifdef ALU_CHK_FAIL_LOG_EN
   logic        fail_seen_q;
   logic [15:0] fail_rp_q;
   logic [15:0] fail_ra_q;

   // First-failure capture; later failures leave the snapshot untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_seen_q <= 1'b0;
         fail_rp_q   <= 16'd0;
         fail_ra_q   <= 16'd0;
      end else if (clear) begin
         fail_seen_q <= 1'b0;
         fail_rp_q   <= 16'd0;
         fail_ra_q   <= 16'd0;
      end else if (fail_s && !fail_seen_q) begin
         fail_seen_q <= 1'b1;
         fail_rp_q   <= R_P;
         fail_ra_q   <= R_A;
      end else begin
         fail_seen_q <= fail_seen_q;
         fail_rp_q   <= fail_rp_q;
         fail_ra_q   <= fail_ra_q;
      end
   end

   assign fail_R_P = fail_rp_q;
   assign fail_R_A = fail_ra_q;
`else
   assign fail_R_P = 16'd0;
   assign fail_R_A = 16'd0;
`endif

   assign busy           = busy_q;
   assign done           = done_q;
   assign match          = match_q;
   assign diff_flags     = diff_q;
   assign test_count     = test_cnt_q;
   assign mismatch_count = mis_cnt_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Randomized self-checking bench for alu_result_checker against a transaction-level reference model.
module tb_alu_result_checker;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] R_P = 16'd0;
   logic [15:0] R_A = 16'd0;
   logic        Co_P = 1'b0, V_P = 1'b0, Z_P = 1'b0;
   logic        Co_A = 1'b0, V_A = 1'b0, Z_A = 1'b0;
   logic        busy, done, match;
   logic [3:0]  diff_flags;
   logic [7:0]  test_count, mismatch_count;
   logic [15:0] fail_R_P, fail_R_A;

   int errors = 0;
   int checks = 0;

   // reference model state
   int          m_tests = 0;
   int          m_mis = 0;
   bit          m_seen = 1'b0;
   logic [15:0] m_frp = 16'd0;
   logic [15:0] m_fra = 16'd0;

   alu_result_checker #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .R_P(R_P), .R_A(R_A),
      .Co_P(Co_P), .V_P(V_P), .Z_P(Z_P), .Co_A(Co_A), .V_A(V_A), .Z_A(Z_A),
      .busy(busy), .done(done), .match(match), .diff_flags(diff_flags),
      .test_count(test_count), .mismatch_count(mismatch_count),
      .fail_R_P(fail_R_P), .fail_R_A(fail_R_A)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_tests = 0; m_mis = 0; m_seen = 1'b0; m_frp = 16'd0; m_fra = 16'd0;
   endtask

   task automatic check_stats(input string tag);
      logic [15:0] efrp, efra;
`ifdef ALU_CHK_FAIL_LOG_EN
      efrp = m_frp; efra = m_fra;
`else
      efrp = 16'd0; efra = 16'd0;
`endif
      checks++;
      if (test_count !== 8'(m_tests)) begin
         errors++; $display("FAIL %s test_count got %0d want %0d", tag, test_count, m_tests);
      end
      checks++;
      if (mismatch_count !== 8'(m_mis)) begin
         errors++; $display("FAIL %s mismatch_count got %0d want %0d", tag, mismatch_count, m_mis);
      end
      checks++;
      if (fail_R_P !== efrp || fail_R_A !== efra) begin
         errors++; $display("FAIL %s fail_log got %h/%h want %h/%h", tag, fail_R_P, fail_R_A, efrp, efra);
      end
   endtask

   // Must be entered just after a negedge; returns just after a negedge.
   task automatic run_compare(input logic [15:0] rp, input logic [15:0] ra,
                              input logic [2:0] fp, input logic [2:0] fa,
                              input bit hold_start, input bit toggle, input bit clr,
                              input string tag);
      int first_done;
      int n_done;
      bit busy_ok;
      logic [3:0] exp_diff;
      R_P = rp; R_A = ra;
      {Co_P, V_P, Z_P} = fp;
      {Co_A, V_A, Z_A} = fa;
      start = 1'b1; clear = 1'b0;
      first_done = -1; n_done = 0; busy_ok = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= S + 4; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_done++;
            if (first_done < 0) first_done = k;
         end
         if (k <= S + 1 && busy !== 1'b1) busy_ok = 1'b0;
         if (k == S + 2 && busy !== 1'b0) busy_ok = 1'b0;
         start = hold_start && (k < 5);
         if (toggle) R_A = (k < S - 1) ? ~ra : ra;
         clear = clr && (k == S);
      end
      clear = 1'b0;
      // model: sequential compare of the COMPARE-cycle values
      exp_diff = {(rp != ra), (fp[2] != fa[2]), (fp[1] != fa[1]), (fp[0] != fa[0])};
      if (clr) begin
         model_reset();
      end else begin
         m_tests = (m_tests + 1) % 256;
         if (exp_diff != 4'd0) begin
            m_mis = (m_mis >= 255) ? 255 : m_mis + 1;
            if (!m_seen) begin
               m_seen = 1'b1; m_frp = rp; m_fra = ra;
            end
         end
      end
      checks++;
      if (first_done != S + 1) begin
         errors++; $display("FAIL %s done_latency got %0d want %0d", tag, first_done, S + 1);
      end
      checks++;
      if (n_done != 1) begin
         errors++; $display("FAIL %s done_count got %0d want 1", tag, n_done);
      end
      checks++;
      if (!busy_ok) begin
         errors++; $display("FAIL %s busy_window got bad want high for %0d cycles", tag, S + 2);
      end
      checks++;
      if (diff_flags !== exp_diff || match !== (exp_diff == 4'd0)) begin
         errors++; $display("FAIL %s result got diff=%b match=%b want diff=%b match=%b",
                            tag, diff_flags, match, exp_diff, (exp_diff == 4'd0));
      end
      check_stats(tag);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, match, diff_flags, test_count, mismatch_count, fail_R_P, fail_R_A} !== 55'd0) begin
         errors++; $display("FAIL reset_state got busy=%b done=%b match=%b diff=%b tc=%0d mc=%0d",
                            busy, done, match, diff_flags, test_count, mismatch_count);
      end
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      run_compare(16'h0000, 16'h0000, 3'b101, 3'b101, 1'b0, 1'b0, 1'b0, "basic_match");
   endtask

   task automatic test_mismatch();
      run_compare(16'hDC5C, 16'hDC5D, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0, "mismatch_R");
      run_compare(16'hDC5C, 16'h0000, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0, "mismatch_second");
      run_compare(16'h1234, 16'h1234, 3'b100, 3'b001, 1'b0, 1'b0, 1'b0, "mismatch_flags");
   endtask

   task automatic test_back_to_back();
      run_compare(16'hA5A5, 16'hA5A5, 3'b011, 3'b011, 1'b1, 1'b1, 1'b0, "hold_toggle");
      run_compare(16'h5A5A, 16'h5A5A, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, "back_to_back");
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_mid_async got busy=%b done=%b want 0/0", busy, done);
      end
      check_stats("reset_mid");
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_mid_hold got busy=%b done=%b want 0/0", busy, done);
      end
      rst_n = 1'b1;
      run_compare(16'h00FF, 16'h00FF, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      logic [15:0] rp, ra;
      logic [2:0]  fp, fa;
      for (int i = 0; i < 24; i++) begin
         rp = 16'($urandom);
         ra = ($urandom_range(0, 1) == 0) ? rp : rp ^ (16'd1 << $urandom_range(0, 15));
         fp = 3'($urandom_range(0, 7));
         fa = ($urandom_range(0, 2) != 0) ? fp : 3'($urandom_range(0, 7));
         run_compare(rp, ra, fp, fa, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "random");
      end
   endtask

   task automatic test_saturation();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      check_stats("idle_clear");
      for (int i = 0; i < 260; i++) begin
         run_compare(16'(i), 16'(i + 1), 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, "saturate");
      end
      checks++;
      if (mismatch_count !== 8'd255 || test_count !== 8'd4) begin
         errors++; $display("FAIL saturation_end got mc=%0d tc=%0d want 255/4", mismatch_count, test_count);
      end
      run_compare(16'hBEEF, 16'hBEEE, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, "clear_at_compare");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mismatch();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
